// File: rtl/fsm_step_controller_pkg.sv
// Shared definitions for the lab7 step sequencer: cause-mask bit positions,
// controller states and a small saturating-increment helper.
package fsm_step_controller_pkg;

  localparam int unsigned CAUSE_TICK = 0;
  localparam int unsigned CAUSE_CHG  = 1;
  localparam int unsigned CAUSE_MAN  = 2;
  localparam int unsigned CAUSE_W    = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a stability counter; a new synced value is
// accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module sync_debounce #(
  parameter int unsigned W               = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_raw,
  output logic [W-1:0] q,
  output logic         changed
);

  localparam int unsigned CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]  r_s1;
  logic [W-1:0]  r_s2;
  logic [W-1:0]  r_q;
  logic [CW-1:0] r_cnt;
  logic          r_chg;

  // r_chg is registered alongside r_q so it marks the first cycle the new value is visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_chg <= 1'b0;
    end else begin
      r_s1  <= d_raw;
      r_s2  <= r_s1;
      r_chg <= 1'b0;
      if (r_s2 != r_q) begin
        if (r_cnt == LAST) begin
          r_q   <= r_s2;
          r_cnt <= '0;
          r_chg <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign q       = r_q;
  assign changed = r_chg;

endmodule

// File: rtl/fsm_step_controller.sv
// Step sequencer for the lab7 microcoded FSM: merges tick, holder-change and manual
// events into one valid/ready step request with a snapped holder value.
module fsm_step_controller
  import fsm_step_controller_pkg::*;
#(
  parameter int unsigned TICK_PERIOD     = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_run,
  input  logic       step_btn,
  input  logic [1:0] holder_raw,
  input  logic       step_ready,
  output logic       step_valid,
  output logic [2:0] step_cause,
  output logic [1:0] step_holder,
  output logic [1:0] holder_db,
  output logic [7:0] coalesce_cnt
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_PERIOD - 1);

  logic               r_mode_s1;
  logic               r_mode_s;
  logic               w_btn_db;
  logic               w_btn_chg;
  logic               w_hold_chg;
  logic [CAUSE_W-1:0] w_ev;

  state_t             r_state, w_state_n;
  logic [CAUSE_W-1:0] r_cause, w_cause_n;
  logic [1:0]         r_holder, w_holder_n;
  logic [7:0]         r_coal, w_coal_n;
  logic [CNT_W-1:0]   r_tick_cnt, w_cnt_n;

  sync_debounce #(.W(2), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hold_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_raw   (holder_raw),
    .q       (holder_db),
    .changed (w_hold_chg)
  );

  sync_debounce #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_raw   (step_btn),
    .q       (w_btn_db),
    .changed (w_btn_chg)
  );

  always_comb begin
    w_ev             = '0;
    w_ev[CAUSE_TICK] = r_mode_s & (r_tick_cnt == TICK_LAST);
    w_ev[CAUSE_CHG]  = w_hold_chg;
    w_ev[CAUSE_MAN]  = w_btn_chg & w_btn_db & ~r_mode_s;
  end

  always_comb begin
    w_state_n  = r_state;
    w_cause_n  = r_cause;
    w_holder_n = r_holder;
    w_coal_n   = r_coal;
    w_cnt_n    = '0;
    case (r_state)
      S_IDLE: begin
        if (|w_ev) begin
          w_state_n  = S_PEND;
          w_cause_n  = w_ev;
          w_holder_n = holder_db;
        end else if (r_mode_s && (r_tick_cnt != TICK_LAST)) begin
          w_cnt_n = r_tick_cnt + CNT_W'(1);
        end
      end
      S_PEND: begin
        // an event coinciding with the handshake starts a fresh request, not a merge
        if (step_ready) begin
          if (|w_ev) begin
            w_cause_n  = w_ev;
            w_holder_n = holder_db;
          end else begin
            w_state_n = S_IDLE;
            w_cause_n = '0;
          end
        end else if (|w_ev) begin
          w_cause_n = r_cause | w_ev;
          w_coal_n  = sat_inc8(r_coal);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_s1  <= 1'b0;
      r_mode_s   <= 1'b0;
      r_state    <= S_IDLE;
      r_cause    <= '0;
      r_holder   <= '0;
      r_coal     <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_mode_s1  <= mode_run;
      r_mode_s   <= r_mode_s1;
      r_state    <= w_state_n;
      r_cause    <= w_cause_n;
      r_holder   <= w_holder_n;
      r_coal     <= w_coal_n;
      r_tick_cnt <= w_cnt_n;
    end
  end

  assign step_valid   = (r_state == S_PEND);
  assign step_cause   = r_cause;
  assign step_holder  = r_holder;
  assign coalesce_cnt = r_coal;

endmodule

// File: tb/tb_fsm_step_controller.sv
// Scoreboard bench for fsm_step_controller: a cycle-level reference model predicts
// each handshake; a separate monitor pops and compares when the DUT hands off a step.
module tb_fsm_step_controller;

  localparam int TP = 10;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_run = 1'b1;
  logic       step_btn = 1'b0;
  logic [1:0] holder_raw = 2'b00;
  logic       step_ready = 1'b1;
  logic       step_valid;
  logic [2:0] step_cause;
  logic [1:0] step_holder;
  logic [1:0] holder_db;
  logic [7:0] coalesce_cnt;

  always #5 clk = ~clk;

  fsm_step_controller #(
    .TICK_PERIOD     (TP),
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_run     (mode_run),
    .step_btn     (step_btn),
    .holder_raw   (holder_raw),
    .step_ready   (step_ready),
    .step_valid   (step_valid),
    .step_cause   (step_cause),
    .step_holder  (step_holder),
    .holder_db    (holder_db),
    .coalesce_cnt (coalesce_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int cause;
    int hold;
    int coal;
  } xact_t;

  xact_t exp_q[$];

  // Reference model state describing the DUT during the current cycle
  int m_h1, m_h2, m_hdb, m_hrun;
  int m_b1, m_b2, m_bdb, m_brun;
  int m_m1, m_ms;
  bit m_hchg, m_bchg;
  int m_idle_run;
  bit m_pend;
  int m_cause, m_hold, m_coal;

  // Accepted value moves to the synced one once it has disagreed for DB cycles in a row
  task automatic db_step(input int s, input int acc_i, input int run_i,
                         output int acc_o, output int run_o, output bit chg);
    acc_o = acc_i;
    chg   = 1'b0;
    if (s != acc_i) begin
      run_o = run_i + 1;
      if (run_o == DB) begin
        acc_o = s;
        run_o = 0;
        chg   = 1'b1;
      end
    end else begin
      run_o = 0;
    end
  endtask

  always @(negedge clk) begin : ref_model
    int    ev;
    bit    tick;
    bit    man;
    xact_t x;
    int    a, r;
    bit    c;
    if (!rst_n) begin
      m_h1 = 0; m_h2 = 0; m_hdb = 0; m_hrun = 0; m_hchg = 0;
      m_b1 = 0; m_b2 = 0; m_bdb = 0; m_brun = 0; m_bchg = 0;
      m_m1 = 0; m_ms = 0; m_idle_run = 0;
      m_pend = 0; m_cause = 0; m_hold = 0; m_coal = 0;
    end else begin
      check("step_valid", step_valid, m_pend);
      check("holder_db", holder_db, m_hdb);
      if (m_pend) check("pending_cause", step_cause, m_cause);

      tick = (m_ms == 1) && (m_idle_run == TP - 1);
      man  = m_bchg && (m_bdb == 1) && (m_ms == 0);
      ev   = (tick ? 1 : 0) | (m_hchg ? 2 : 0) | (man ? 4 : 0);

      if (m_pend && step_ready) begin
        x.cause = m_cause; x.hold = m_hold; x.coal = m_coal;
        exp_q.push_back(x);
      end

      if ((m_ms == 1) && !m_pend && (ev == 0) && (m_idle_run != TP - 1))
        m_idle_run = m_idle_run + 1;
      else
        m_idle_run = 0;

      if (m_pend && !step_ready) begin
        if (ev != 0) begin
          m_cause = m_cause | ev;
          if (m_coal < 255) m_coal = m_coal + 1;
        end
      end else if (ev != 0) begin
        m_pend = 1; m_cause = ev; m_hold = m_hdb;
      end else if (m_pend) begin
        m_pend = 0; m_cause = 0;
      end

      db_step(m_h2, m_hdb, m_hrun, a, r, c);
      m_hdb = a; m_hrun = r; m_hchg = c;
      db_step(m_b2, m_bdb, m_brun, a, r, c);
      m_bdb = a; m_brun = r; m_bchg = c;

      m_h2 = m_h1; m_h1 = int'(holder_raw);
      m_b2 = m_b1; m_b1 = int'(step_btn);
      m_ms = m_m1; m_m1 = int'(mode_run);
    end
  end

  int obs_tick = 0;
  int obs_chg  = 0;
  int obs_man  = 0;

  always @(negedge clk) begin : monitor
    xact_t x;
    #1;
    if (rst_n && step_valid && step_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_step: got cause %0d, expected no step (t=%0t)", step_cause, $time);
      end else begin
        x = exp_q.pop_front();
        check("step_cause", step_cause, x.cause);
        check("step_holder", step_holder, x.hold);
        check("coalesce_cnt", coalesce_cnt, x.coal);
      end
      if (step_cause[0]) obs_tick++;
      if (step_cause[1]) obs_chg++;
      if (step_cause[2]) obs_man++;
    end
  end

  task automatic step_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int limit, input string name);
    int k = 0;
    while (!step_valid && k < limit) begin
      step_cyc();
      k++;
    end
    check(name, step_valid, 1);
  endtask

  int c0, m0;

  initial begin
    #3;
    check("reset_valid", step_valid, 0);
    check("reset_cause", step_cause, 0);
    check("reset_holder", step_holder, 0);
    check("reset_holder_db", holder_db, 0);
    check("reset_coalesce", coalesce_cnt, 0);
    step_cyc();
    step_cyc();
    rst_n = 1'b1;

    // free-running ticks with the FSM always ready
    repeat (60) step_cyc();
    check("tick_steps_in_60", obs_tick, 5);

    // clean holder change, ticks off
    mode_run = 1'b0;
    repeat (4) step_cyc();
    holder_raw = 2'b10;
    repeat (5) step_cyc();
    check("holder_db_before_accept", holder_db, 0);
    step_cyc();
    check("holder_db_accept", holder_db, 2);
    step_cyc();
    check("change_valid", step_valid, 1);
    check("change_cause", step_cause, 2);
    check("change_holder", step_holder, 2);
    step_cyc();
    check("change_valid_drop", step_valid, 0);

    // bouncing holder settles into exactly one change step
    holder_raw = 2'b00;
    repeat (10) step_cyc();
    c0 = obs_chg;
    for (int i = 0; i < 3; i++) begin
      holder_raw = 2'b10;
      repeat (2) step_cyc();
      holder_raw = 2'b00;
      repeat (2) step_cyc();
      check("bounce_no_update", holder_db, 0);
    end
    holder_raw = 2'b10;
    repeat (12) step_cyc();
    check("bounce_settled", holder_db, 2);
    check("bounce_one_step", obs_chg - c0, 1);

    // tick then change while stalled merge into one request
    mode_run   = 1'b1;
    step_ready = 1'b0;
    wait_valid(30, "merge_tick_valid");
    check("merge_first_cause", step_cause, 1);
    holder_raw = 2'b01;
    repeat (8) step_cyc();
    check("merge_valid", step_valid, 1);
    check("merge_cause", step_cause, 3);
    check("merge_coalesce", coalesce_cnt, 1);
    check("merge_holder_kept", step_holder, 2);
    step_ready = 1'b1;
    repeat (2) step_cyc();
    check("merge_drained", step_valid, 0);

    // manual button in step mode, then ignored in run mode
    mode_run = 1'b0;
    repeat (4) step_cyc();
    m0 = obs_man;
    step_btn = 1'b1;
    repeat (10) step_cyc();
    step_btn = 1'b0;
    repeat (10) step_cyc();
    check("manual_step", obs_man - m0, 1);
    mode_run = 1'b1;
    repeat (4) step_cyc();
    m0 = obs_man;
    step_btn = 1'b1;
    repeat (10) step_cyc();
    step_btn = 1'b0;
    repeat (10) step_cyc();
    check("manual_ignored_in_run", obs_man - m0, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) holder_raw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 99) == 0) mode_run = ~mode_run;
      step_ready = ($urandom_range(0, 3) != 0);
      step_cyc();
    end

    // saturate the coalesce counter with a long stall
    mode_run   = 1'b0;
    step_btn   = 1'b0;
    step_ready = 1'b0;
    repeat (4) step_cyc();
    for (int i = 0; i < 265; i++) begin
      holder_raw = holder_raw ^ 2'b01;
      repeat (7) step_cyc();
    end
    check("coalesce_saturated", coalesce_cnt, 255);
    step_ready = 1'b1;
    repeat (3) step_cyc();

    // asynchronous reset while a request is pending
    mode_run   = 1'b1;
    step_ready = 1'b0;
    wait_valid(40, "pre_reset_valid");
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", step_valid, 0);
    check("async_rst_cause", step_cause, 0);
    check("async_rst_holder", step_holder, 0);
    check("async_rst_holder_db", holder_db, 0);
    check("async_rst_coalesce", coalesce_cnt, 0);
    step_cyc();
    step_cyc();
    step_ready = 1'b1;
    rst_n = 1'b1;
    c0 = obs_tick;
    repeat (30) step_cyc();
    check("ticks_after_reset", obs_tick - c0, 2);

    repeat (2) step_cyc();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
